// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types for the configurable UART receiver.
// Rev 1.0
`default_nettype none

package uart_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Data field is sized for the widest frame; narrower frames are zero-extended.
  typedef struct packed {
    logic [7:0] data;
    logic       frame_err;
    logic       parity_err;
  } entry_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous show-ahead FIFO; the head word is visible without a pop.
// Rev 1.0
`default_nettype none

module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [LW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == LW'(DEPTH));
  assign level   = cnt;
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push while full is still accepted.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parameterised UART receiver with glitch filter, error flags and receive FIFO.
// Rev 1.0
`default_nettype none

module uart_rx_cfg
  import uart_rx_pkg::*;
#(
  parameter int CLK_DIV    = 234,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rxd,
  output logic [DATA_BITS-1:0]            data,
  output logic                            frame_err,
  output logic                            parity_err,
  output logic                            req,
  input  logic                            ack,
  output logic                            overrun,
  input  logic                            ovr_clr,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] level,
  output logic                            busy
);

  localparam logic [15:0] BIT_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLK_DIV / 2 - 1);
  localparam logic [2:0]  DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

  logic                 sync1, sync2, filt_q;
  logic [2:0]           hist;
  logic                 filt;
  state_t               state;
  logic [15:0]          cnt;
  logic [2:0]           bitcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr, ferr;
  logic                 sample, push, pop, full, empty;
  entry_t               wentry, head;

  assign filt   = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
  assign sample = (state == S_START) ? (cnt == HALF_LAST) : (cnt == BIT_LAST);
  assign push   = (state == S_STOP) && sample && (bitcnt == STOP_LAST);
  assign pop    = ack && req;

  assign wentry.data       = 8'(shreg);
  assign wentry.frame_err  = ferr | ~filt;
  assign wentry.parity_err = perr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      hist   <= 3'b111;
      filt_q <= 1'b1;
    end else begin
      sync1  <= rxd;
      sync2  <= sync1;
      hist   <= {hist[1:0], sync2};
      filt_q <= filt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      bitcnt <= '0;
      shreg  <= '0;
      perr   <= 1'b0;
      ferr   <= 1'b0;
    end else begin
      if (state == S_IDLE || state == S_WAIT_HIGH || sample) cnt <= '0;
      else                                                   cnt <= cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (filt_q && !filt) begin
            state  <= S_START;
            bitcnt <= '0;
            perr   <= 1'b0;
            ferr   <= 1'b0;
          end
        end
        S_START: begin
          if (sample) state <= filt ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          if (sample) begin
            shreg <= {filt, shreg[DATA_BITS-1:1]};
            if (bitcnt == DATA_LAST) begin
              bitcnt <= '0;
              state  <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
            end else begin
              bitcnt <= bitcnt + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (sample) begin
            perr  <= (^shreg ^ filt) ^ (PARITY == PAR_ODD);
            state <= S_STOP;
          end
        end
        S_STOP: begin
          if (sample) begin
            ferr <= ferr | ~filt;
            if (bitcnt == STOP_LAST) begin
              bitcnt <= '0;
              // A low stop bit may be a break; wait for the line to recover first.
              state  <= (ferr | ~filt) ? S_WAIT_HIGH : S_IDLE;
            end else begin
              bitcnt <= bitcnt + 1'b1;
            end
          end
        end
        S_WAIT_HIGH: begin
          if (filt) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)                  overrun <= 1'b0;
    else if (push && full && !pop) overrun <= 1'b1;
    else if (ovr_clr)          overrun <= 1'b0;
  end

  uart_rx_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign req        = !empty;
  assign data       = head.data[DATA_BITS-1:0];
  assign frame_err  = head.frame_err;
  assign parity_err = head.parity_err;
  assign busy       = (state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: scoreboard bench for uart_rx_cfg (8N1 and 8E1 instances, CLK_DIV=16).
// Rev 1.0
`default_nettype none

module tb_uart_rx_cfg;

  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxd = 1'b1, rxd_p = 1'b1;
  logic       ack = 1'b0, ovr_clr = 1'b0;
  logic       sel = 1'b0;

  logic [7:0] data_m, data_p;
  logic       fe_m, fe_p, pe_m, pe_p, req_m, req_p, ovr_m, ovr_p, busy_m, busy_p;
  logic [2:0] level_m, level_p;

  logic [7:0] data_s;
  logic       fe_s, pe_s, req_s;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign data_s = sel ? data_p : data_m;
  assign fe_s   = sel ? fe_p   : fe_m;
  assign pe_s   = sel ? pe_p   : pe_m;
  assign req_s  = sel ? req_p  : req_m;

  uart_rx_cfg #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .data(data_m), .frame_err(fe_m), .parity_err(pe_m),
    .req(req_m), .ack(ack && !sel), .overrun(ovr_m), .ovr_clr(ovr_clr), .level(level_m),
    .busy(busy_m));

  uart_rx_cfg #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_p (
    .clk(clk), .rst(rst), .rxd(rxd_p), .data(data_p), .frame_err(fe_p), .parity_err(pe_p),
    .req(req_p), .ack(ack && sel), .overrun(ovr_p), .ovr_clr(ovr_clr), .level(level_p),
    .busy(busy_p));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] frame8(input logic [7:0] b);
    return {6'b0, 1'b1, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel) rxd_p = bits[i];
      else     rxd   = bits[i];
      repeat (DIV) @(negedge clk);
    end
  endtask

  task automatic expect_word(input logic [7:0] d, input logic fe, input logic pe);
    exp_t e;
    e.d = d; e.fe = fe; e.pe = pe;
    sb.push_back(e);
  endtask

  task automatic drain_one();
    exp_t e;
    int   t;
    t = 0;
    while (!req_s && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!req_s) check("req_timeout", 32'(req_s), 32'd1);
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("data",       32'(data_s), 32'(e.d));
      check("frame_err",  32'(fe_s),   32'(e.fe));
      check("parity_err", 32'(pe_s),   32'(e.pe));
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_data",  32'(data_m), 32'd0);
    check("rst_req",   32'(req_m),  32'd0);
    check("rst_fe",    32'(fe_m),   32'd0);
    check("rst_pe",    32'(pe_m),   32'd0);
    check("rst_ovr",   32'(ovr_m),  32'd0);
    check("rst_level", 32'(level_m), 32'd0);
    check("rst_busy",  32'(busy_m), 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 0xA5: req only appears after the mid-stop sample
    send_bits(frame8(8'hA5), 9);
    check("a5_req_pre_stop", 32'(req_m), 32'd0);
    send_bits(16'h1, 1);
    check("a5_req_after_stop", 32'(req_m), 32'd1);
    expect_word(8'hA5, 1'b0, 1'b0);
    drain_one();
    check("a5_level_after_pop", 32'(level_m), 32'd0);

    // Even parity: 0x03 with parity bit 1 is wrong, with parity bit 0 is right
    sel = 1'b1;
    send_bits({5'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
    expect_word(8'h03, 1'b0, 1'b1);
    drain_one();
    send_bits({5'b0, 1'b1, 1'b0, 8'h03, 1'b0}, 11);
    expect_word(8'h03, 1'b0, 1'b0);
    drain_one();
    sel = 1'b0;

    // 4-clock glitch is rejected as a false start
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (12) @(negedge clk);
    check("glitch_busy", 32'(busy_m), 32'd0);
    check("glitch_req",  32'(req_m),  32'd0);

    // Break for three frame times yields exactly one errored word
    rxd = 1'b0;
    repeat (3 * 10 * DIV) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    check("break_level", 32'(level_m), 32'd1);
    expect_word(8'h00, 1'b1, 1'b0);
    drain_one();
    check("break_level_after", 32'(level_m), 32'd0);

    // Fill past depth: fifth word dropped, overrun sticky until cleared
    for (int i = 1; i <= 5; i++) begin
      send_bits(frame8(8'(i)), 10);
      if (i <= 4) expect_word(8'(i), 1'b0, 1'b0);
    end
    repeat (20) @(negedge clk);
    check("fill_level",   32'(level_m), 32'd4);
    check("fill_overrun", 32'(ovr_m),   32'd1);
    for (int i = 0; i < 4; i++) drain_one();
    check("ovr_sticky", 32'(ovr_m), 32'd1);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    check("ovr_cleared", 32'(ovr_m), 32'd0);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("ack_idle_level", 32'(level_m), 32'd0);
    check("ack_idle_req",   32'(req_m),   32'd0);

    // Reset during bit 3 of 0x5A abandons it; 0x3C is then the only word
    send_bits(frame8(8'h5A), 4);
    rst = 1'b0;
    send_bits(frame8(8'h5A) >> 4, 6);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst_level", 32'(level_m), 32'd0);
    check("midrst_busy",  32'(busy_m),  32'd0);
    send_bits(frame8(8'h3C), 10);
    expect_word(8'h3C, 1'b0, 1'b0);
    drain_one();
    repeat (4 * DIV) @(negedge clk);
    check("midrst_level_end", 32'(level_m), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 234: clocks per bit, legal range 8..65535.
REQ-002 SHALL provide parameter DATA_BITS, default 8: data bits per frame, legal range 5..8.
REQ-003 SHALL provide parameter PARITY, default 0: 0 none, 1 even, 2 odd.
REQ-004 SHALL provide parameter STOP_BITS, default 1: legal values 1 or 2.
REQ-005 SHALL provide parameter FIFO_DEPTH, default 4: receive FIFO entries, power of 2, legal range 2..64.
REQ-006 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous and active-low.
REQ-008 SHALL have port rxd, input, 1: asynchronous serial line, idle high.
REQ-009 SHALL have port data, output, DATA_BITS: head FIFO word.
REQ-010 SHALL have port frame_err, output, 1: head word had a low stop bit.
REQ-011 SHALL have port parity_err, output, 1: head word had a parity mismatch.
REQ-012 SHALL have port req, output, 1: FIFO non-empty, so data and flags are valid.
REQ-013 SHALL have port ack, input, 1: consumer pops the head word when req=1 and ack=1.
REQ-014 SHALL have port overrun, output, 1: sticky flag, set when a word is dropped.
REQ-015 SHALL have port ovr_clr, input, 1: clears overrun.
REQ-016 SHALL have port level, output, clog2(FIFO_DEPTH+1): FIFO occupancy.
REQ-017 SHALL have port busy, output, 1: receiver FSM not in IDLE.

Function
REQ-018 SHALL synchronise rxd through 2 flops, then filter by majority of the last 3 synchronised samples (at least 2 ones gives 1).
REQ-019 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-020 In IDLE, a filtered falling edge (1 to 0) SHALL clear the bit counter and enter START.
REQ-021 START SHALL sample at count CLK_DIV/2-1; filtered=1 at that point is a false start and SHALL return to IDLE with no push.
REQ-022 Each subsequent sample SHALL occur exactly CLK_DIV clocks after the previous one; the counter wraps at CLK_DIV-1.
REQ-023 DATA SHALL capture DATA_BITS samples LSB-first, then go to PARITY if PARITY!=0, else to STOP.
REQ-024 PARITY SHALL flag parity_err when XOR(data bits, parity bit) is 1 for even, or 0 for odd.
REQ-025 STOP SHALL sample STOP_BITS bits; any low stop sample SHALL flag frame_err.
REQ-026 At the final stop sample, the word and its flags SHALL be pushed in that same cycle; errored words are pushed too.
REQ-027 After the push, the FSM SHALL enter IDLE if no frame_err, else WAIT_HIGH.
REQ-028 WAIT_HIGH SHALL hold until filtered=1, then enter IDLE, so a break yields exactly one word.
REQ-029 req SHALL assert the cycle after a push into an empty FIFO.
REQ-030 data, frame_err and parity_err SHALL be stable while req=1 and ack=0.
REQ-031 A push while full SHALL drop the new word, set overrun, and leave the FIFO unchanged.
REQ-032 Push and pop in the same cycle while full SHALL accept both, with no overrun.
REQ-033 Push and pop in the same cycle while non-full and non-empty SHALL leave level unchanged.
REQ-034 ack while req=0 SHALL be ignored.
REQ-035 If overrun set and ovr_clr occur in the same cycle, set SHALL win.
REQ-036 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-037 level SHALL saturate at FIFO_DEPTH.

Reset
REQ-038 While rst=0 at a clk edge: FSM to IDLE, counters 0, sync/filter flops 1, FIFO empty.
REQ-039 While rst=0: data=0, req=0, frame_err=0, parity_err=0, overrun=0, level=0, busy=0.
REQ-040 Reset mid-frame SHALL abandon the frame with no push; the next frame SHALL start from a fresh falling edge.

Structure
REQ-041 Package uart_rx_pkg SHALL hold the FSM state typedef, parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) and the entry record {data, frame_err, parity_err}.
REQ-042 SHALL instantiate one sub-module uart_rx_fifo (synchronous FIFO, show-ahead head, parameterised width and depth).

Verification (CLK_DIV=16)
REQ-043 8N1 frame 0xA5 SHALL give req one cycle after the mid-stop sample, with data=0xA5 and both error flags 0.
REQ-044 PARITY=1, frame 0x03 with parity bit 1 SHALL give data=0x03 and parity_err=1.
REQ-045 A 4-clock low glitch on an idle line SHALL give no req and busy back to 0 within 12 clocks.
REQ-046 Line held low for 3 frame times, then released, SHALL give exactly one word: data=0x00, frame_err=1.
REQ-047 FIFO_DEPTH=4, frames 0x01..0x05 with ack=0, SHALL give level=4 and overrun=1; four acks then read 0x01..0x04, and ovr_clr clears overrun.
REQ-048 rst=0 during bit 3 of 0x5A, then frame 0x3C, SHALL give a single word 0x3C.
